// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder slice.
// Holds the FSM state encoding, bus widths and the address legality check.
package mem_if_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word-aligned and inside [base, base + depth*4); arithmetic is 32-bit unsigned.
  function automatic logic addr_ok(input logic [WORD_W-1:0] addr,
                                   input logic [WORD_W-1:0] base,
                                   input int unsigned       depth);
    logic [WORD_W-1:0] off;
    off = addr - base;
    return (addr[1:0] == 2'b00) && (addr >= base) && ((off >> 2) < depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the core's load/store port and the responder.
// The core drives the master side; the responder implements the slave side.
interface data_mem_responder_if;
  import mem_if_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_word_array.sv
// Word array with per-byte write mask: synchronous write, combinational read, no reset.
// Read and write share one index; the read shows pre-write contents during a write cycle.
module mem_word_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states, then a held response.
// Access is committed on the edge entering RESP; illegal addresses answer with rsp_err and no write.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int                DEPTH_WORDS = 256,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [WORD_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic               CLK,
  input logic               RST,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t            state, state_n;
  logic [3:0]        cnt;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [WORD_W-1:0] rsp_rdata_q;

  logic              accept, enter_resp, arr_we, cur_we, cur_err;
  logic [WORD_W-1:0] cur_addr, cur_wdata, cur_off, arr_rdata;
  logic [BE_W-1:0]   cur_be;
  logic [IDX_W-1:0]  arr_idx;

  assign bus.req_ready = (state == IDLE) && !RST;
  assign accept        = bus.req_ready && bus.req_valid;

  // With zero wait states the commit coincides with the accept edge, so use the live request.
  assign cur_we    = (state == IDLE) ? bus.req_we    : we_q;
  assign cur_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
  assign cur_be    = (state == IDLE) ? bus.req_be    : be_q;
  assign cur_err   = !addr_ok(cur_addr, BASE_ADDR, DEPTH_WORDS);
  assign cur_off   = cur_addr - BASE_ADDR;
  assign arr_idx   = IDX_W'(cur_off >> 2);
  assign arr_we    = enter_resp && cur_we && !cur_err;

  always_comb begin
    state_n    = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        if (WAIT_CYCLES == 0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_n    = RESP;
        enter_resp = 1'b1;
      end
      RESP:    if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A reset edge during WAIT must not commit the pending store.
    if (RST) begin
      state_n    = IDLE;
      enter_resp = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
        cnt     <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= cur_err;
        rsp_rdata_q <= (!cur_we && !cur_err) ? arr_rdata : '0;
      end else if (state == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= '0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_arr (
    .CLK   (CLK),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with 0, 1 and 3 wait states (one instance each).
// Inputs change and outputs are sampled on the falling edge.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic [2:0]  rst;
  logic [1:0]  sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  int          compared   = 0;
  int          mismatched = 0;

  always #5 CLK = ~CLK;

  data_mem_responder_if if0 ();
  data_mem_responder_if if1 ();
  data_mem_responder_if if3 ();

  assign if0.req_valid = req_valid && (sel == 2'd0);
  assign if1.req_valid = req_valid && (sel == 2'd1);
  assign if3.req_valid = req_valid && (sel == 2'd2);
  assign {if0.req_we, if1.req_we, if3.req_we}          = {3{req_we}};
  assign {if0.req_addr, if1.req_addr, if3.req_addr}    = {3{req_addr}};
  assign {if0.req_wdata, if1.req_wdata, if3.req_wdata} = {3{req_wdata}};
  assign {if0.req_be, if1.req_be, if3.req_be}          = {3{req_be}};
  assign {if0.rsp_ready, if1.rsp_ready, if3.rsp_ready} = {3{rsp_ready}};

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
    .CLK(CLK), .RST(rst[0]), .bus(if0.slave));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_w1 (
    .CLK(CLK), .RST(rst[1]), .bus(if1.slave));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_w3 (
    .CLK(CLK), .RST(rst[2]), .bus(if3.slave));

  always_comb begin
    case (sel)
      2'd0: {o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata} =
              {if0.req_ready, if0.rsp_valid, if0.rsp_err, if0.rsp_rdata};
      2'd1: {o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata} =
              {if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.rsp_rdata};
      default: {o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata} =
              {if3.req_ready, if3.rsp_valid, if3.rsp_err, if3.rsp_rdata};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance, starting and ending at a falling edge.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int exp_lat,
                     input int hold, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    chk({tag, "/req_ready_before"}, 32'(o_req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin
      @(posedge CLK);
      @(negedge CLK);
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      chk({tag, "/hold_valid"}, 32'(o_rsp_valid), 32'd1);
      chk({tag, "/hold_req_ready"}, 32'(o_req_ready), 32'd0);
      chk({tag, "/hold_rdata"}, o_rsp_rdata, exp_rdata);
      chk({tag, "/hold_err"}, 32'(o_rsp_err), 32'(exp_err));
      @(posedge CLK);
      @(negedge CLK);
    end
    chk({tag, "/rdata"}, o_rsp_rdata, exp_rdata);
    chk({tag, "/err"}, 32'(o_rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk({tag, "/valid_cleared"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "/rdata_cleared"}, o_rsp_rdata, 32'd0);
    chk({tag, "/req_ready_after"}, 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 3'b111; sel = 2'd1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("reset/req_ready_in_rst", 32'(o_req_ready), 32'd0);
    chk("reset/rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset/rsp_rdata", o_rsp_rdata, 32'd0);
    chk("reset/rsp_err", 32'(o_rsp_err), 32'd0);
    rst = 3'b000;
    #1;
    chk("reset/req_ready_w1", 32'(o_req_ready), 32'd1);
    @(negedge CLK);

    // 1: full-word store then load, two cycles each
    txn("t1_st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 0, 32'h0, 1'b0);
    txn("t1_ld10", 1'b0, 32'h10, 32'h0, 4'h0, 2, 0, 32'hDEADBEEF, 1'b0);

    // 2: partial-byte merge
    txn("t2_st20", 1'b1, 32'h20, 32'h11223344, 4'hF, 2, 0, 32'h0, 1'b0);
    txn("t2_st20_be5", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 2, 0, 32'h0, 1'b0);
    txn("t2_ld20", 1'b0, 32'h20, 32'h0, 4'h0, 2, 0, 32'h11BB33DD, 1'b0);
    txn("t2_st20_be0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 2, 0, 32'h0, 1'b0);
    txn("t2_ld20_be0", 1'b0, 32'h20, 32'h0, 4'hF, 2, 0, 32'h11BB33DD, 1'b0);

    // 3: misaligned / out-of-range accesses error out without touching the array
    txn("t3_st0", 1'b1, 32'h0, 32'h01020304, 4'hF, 2, 0, 32'h0, 1'b0);
    txn("t3_ld22", 1'b0, 32'h22, 32'h0, 4'hF, 2, 0, 32'h0, 1'b1);
    txn("t3_ld400", 1'b0, 32'h400, 32'h0, 4'hF, 2, 0, 32'h0, 1'b1);
    txn("t3_st11", 1'b1, 32'h11, 32'h0, 4'hF, 2, 0, 32'h0, 1'b1);
    txn("t3_st400", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 2, 0, 32'h0, 1'b1);
    txn("t3_ld10_chk", 1'b0, 32'h10, 32'h0, 4'h0, 2, 0, 32'hDEADBEEF, 1'b0);
    txn("t3_ld0_chk", 1'b0, 32'h0, 32'h0, 4'h0, 2, 0, 32'h01020304, 1'b0);

    // 4: back-pressure for 5 cycles
    txn("t4_bp", 1'b0, 32'h10, 32'h0, 4'h0, 2, 5, 32'hDEADBEEF, 1'b0);

    // 5: reset during WAIT drops the pending store
    sel = 2'd2;
    #1;
    txn("t5_st30", 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 4, 0, 32'h0, 1'b0);
    chk("t5/req_ready", 32'(o_req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("t5/in_wait_valid", 32'(o_rsp_valid), 32'd0);
    chk("t5/in_wait_req_ready", 32'(o_req_ready), 32'd0);
    rst[2] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rst[2] = 1'b0;
    #1;
    chk("t5/post_rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("t5/post_rst_req_ready", 32'(o_req_ready), 32'd1);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("t5/idle_valid", 32'(o_rsp_valid), 32'd0);
    txn("t5_ld30", 1'b0, 32'h30, 32'h0, 4'h0, 4, 0, 32'hCAFEF00D, 1'b0);

    // 6: zero wait states, back-to-back loads with rsp_ready held high
    sel = 2'd0;
    #1;
    txn("t6_st10", 1'b1, 32'h10, 32'h0BADCAFE, 4'hF, 1, 0, 32'h0, 1'b0);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = '0; req_be = 4'h0;
    chk("t6/req_ready_start", 32'(o_req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (i % 2 == 0) begin
        chk("t6/b2b_valid_hi", 32'(o_rsp_valid), 32'd1);
        chk("t6/b2b_ready_lo", 32'(o_req_ready), 32'd0);
        chk("t6/b2b_rdata", o_rsp_rdata, 32'h0BADCAFE);
      end else begin
        chk("t6/b2b_valid_lo", 32'(o_rsp_valid), 32'd0);
        chk("t6/b2b_ready_hi", 32'(o_req_ready), 32'd1);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge CLK);
    chk("t6/quiet_valid", 32'(o_rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
